sevenseg_scan: RTL and testbench
================================

SEVENSEG_SCAN -- requirements
Module: sevenseg_scan

Interface
REQ-001 The module SHALL accept parameter N_DIGITS, default 4, the number of multiplexed digits (range 1-8).
REQ-002 The module SHALL accept parameter IN_W, default 14, the width of the binary input value.
REQ-003 The module SHALL accept parameter REFRESH_DIV, default 5000, the number of clk cycles each digit is held (minimum 2).
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 load_valid  input  1  high when value is presented for display.
REQ-007 value  input  IN_W  unsigned binary number to display.
REQ-008 load_ready  output  1  high when a new value is accepted.
REQ-009 seg  output  7  segment drive {a,b,c,d,e,f,g}, a in bit 6; active-low (0 = lit).
REQ-010 digit_sel  output  N_DIGITS  one-hot digit enable, active-high; bit 0 = most significant (leftmost) digit.
REQ-011 overflow  output  1  high while the displayed value exceeds 10^N_DIGITS - 1.

Function
REQ-012 A load SHALL occur on a cycle where load_valid and load_ready are both high; value is captured that cycle, and load_valid is ignored when load_ready is low.
REQ-013 load_ready SHALL go low the cycle after a load and stay low for exactly IN_W cycles of sequential double-dabble conversion, one input bit per cycle, then return high.
REQ-014 The shown digits SHALL update atomically on the cycle load_ready returns high; no partially converted digit is ever driven.
REQ-015 The cycle load_ready returns high, overflow SHALL be set to 1 if the captured value > 10^N_DIGITS - 1 and to 0 otherwise; while overflow is 1, every digit SHALL show seg = 7'b1111110 (g only).
REQ-016 A refresh counter SHALL count 0..REFRESH_DIV-1 and wrap; on the wrap cycle the digit index SHALL advance by 1, wrapping from N_DIGITS-1 to 0.
REQ-017 digit_sel and seg SHALL be registered from the same digit index, so they change on the same clk edge; there is no one-cycle segment/select skew.
REQ-018 Digit encoding (seg, active-low): 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100; any other code = 1111111.
REQ-019 Scanning SHALL continue uninterrupted during conversion, showing the previously converted value.
REQ-020 value = 0 SHALL produce all digits 0 (subject to REQ-027); value = 10^N_DIGITS - 1 SHALL produce all 9s with overflow 0.

Reset
REQ-021 While rst_n is low: seg = 7'b1111111, digit_sel = one-hot bit 0, load_ready = 1, overflow = 0, and refresh counter, digit index and displayed digits = 0.
REQ-022 rst_n asserted mid-conversion SHALL abort the conversion; the displayed digits after release SHALL be 0.
REQ-023 The first digit change after rst_n deasserts SHALL occur REFRESH_DIV cycles after the first rising clk edge.

Configuration
REQ-024 The module SHALL use macro SEVENSEG_BLANK_EN.
REQ-025 Without SEVENSEG_BLANK_EN, all digits SHALL be shown, including leading zeros.
REQ-026 With SEVENSEG_BLANK_EN, every zero digit to the left of the most significant non-zero digit SHALL show seg = 7'b1111111.
REQ-027 With SEVENSEG_BLANK_EN, the least significant digit SHALL always be shown, so value 0 displays a single "0"; overflow dashes are never blanked.

Verification
REQ-028 N_DIGITS=4, value=1234 loaded -> load_ready low 14 cycles; then scan shows digit_sel 0001/0010/0100/1000 with seg 1001111/0010010/0000110/1001100.
REQ-029 value=10000 (N_DIGITS=4) -> overflow=1; all four digits show 1111110.
REQ-030 SEVENSEG_BLANK_EN defined, value=7 -> digits 0-2 show 1111111; digit 3 shows 0001111; value=0 -> only digit 3 shows 0000001.
REQ-031 load_valid held high during conversion with value=5555 -> ignored; the display shows the first loaded value only.
REQ-032 REFRESH_DIV=4 -> digit_sel advances every 4 cycles and wraps 1000 -> 0001; seg changes on the same edge as digit_sel.
REQ-033 rst_n pulsed low 5 cycles into the conversion of 9999 -> outputs take REQ-021 values immediately; after release load_ready=1 and the display shows 0.

Source files
------------

// File: rtl/sevenseg_scan_if.sv
// Load handshake between a value producer and the seven-segment scanner.
// The master presents value/load_valid; the scanner (slave) answers with load_ready.
interface sevenseg_scan_if #(
    parameter int IN_W = 14
) ();
    logic            load_valid;
    logic            load_ready;
    logic [IN_W-1:0] value;

    modport master (output load_valid, output value, input load_ready);
    modport slave  (input load_valid, input value, output load_ready);
endinterface

// File: rtl/sevenseg_scan.sv
// Multiplexed seven-segment driver: serial double-dabble conversion plus digit scanning.
// Optional build macro SEVENSEG_BLANK_EN blanks leading zeros (least significant digit always shown).
//
// state  | meaning
// S_IDLE | load_ready high, waiting for a value
// S_CONV | shifting one input bit per cycle into the BCD accumulator
module sevenseg_scan #(
    parameter int N_DIGITS    = 4,
    parameter int IN_W        = 14,
    parameter int REFRESH_DIV = 5000
) (
    input  logic                clk,
    input  logic                rst_n,
    sevenseg_scan_if.slave      ld_if,
    output logic [6:0]          seg,
    output logic [N_DIGITS-1:0] digit_sel,
    output logic                overflow
);
    localparam int DW    = 4 * N_DIGITS;
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int RW    = $clog2(REFRESH_DIV);
    localparam int CW    = (IN_W > 1) ? $clog2(IN_W) : 1;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) p = p * 64'd10;
        return p;
    endfunction

    localparam logic [63:0] MAX_VAL = pow10(N_DIGITS) - 64'd1;

    function automatic logic [6:0] seg_for(input logic [DW-1:0] d, input logic ovf,
                                           input logic [IDX_W-1:0] idx);
        logic [3:0] nib;
        logic [6:0] s;
        nib = d[4*(N_DIGITS-1-int'(idx)) +: 4];
        case (nib)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = 7'b1111111;
        endcase
`ifdef SEVENSEG_BLANK_EN
        begin
            logic lead_zero;
            lead_zero = 1'b1;
            for (int j = 0; j < N_DIGITS; j++) begin
                if (j <= int'(idx) && d[4*(N_DIGITS-1-j) +: 4] != 4'd0) lead_zero = 1'b0;
            end
            if (lead_zero && int'(idx) != N_DIGITS - 1) s = 7'b1111111;
        end
`endif
        if (ovf) s = 7'b1111110;
        return s;
    endfunction

    typedef enum logic {S_IDLE, S_CONV} state_t;

    state_t                state_q;
    logic [IN_W-1:0]       shift_q;
    logic [DW-1:0]         bcd_q, bcd_adj, bcd_step;
    logic [DW-1:0]         disp_q, disp_d;
    logic [CW-1:0]         bit_cnt_q;
    logic                  ovf_pend_q, ovf_q, ovf_d;
    logic [RW-1:0]         ref_cnt_q, ref_cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [6:0]            seg_q;
    logic [N_DIGITS-1:0]   sel_q;
    logic                  load_fire, conv_done, ref_wrap;

    assign ld_if.load_ready = (state_q == S_IDLE);
    assign load_fire        = ld_if.load_valid && (state_q == S_IDLE);
    assign conv_done        = (state_q == S_CONV) && (bit_cnt_q == '0);

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        bcd_step = {bcd_adj[DW-2:0], shift_q[IN_W-1]};

        // Digits and overflow flag swap together only on the final conversion step.
        disp_d = conv_done ? bcd_step : disp_q;
        ovf_d  = conv_done ? ovf_pend_q : ovf_q;

        ref_wrap  = (ref_cnt_q == RW'(REFRESH_DIV - 1));
        ref_cnt_d = ref_wrap ? '0 : ref_cnt_q + 1'b1;
        idx_d     = idx_q;
        if (ref_wrap) idx_d = (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            bcd_q      <= '0;
            bit_cnt_q  <= '0;
            ovf_pend_q <= 1'b0;
            disp_q     <= '0;
            ovf_q      <= 1'b0;
            ref_cnt_q  <= '0;
            idx_q      <= '0;
            seg_q      <= 7'b1111111;
            sel_q      <= N_DIGITS'(1);
        end else begin
            ref_cnt_q <= ref_cnt_d;
            idx_q     <= idx_d;
            disp_q    <= disp_d;
            ovf_q     <= ovf_d;
            // Select and segments come from the same next index, so they move on one edge.
            seg_q     <= seg_for(disp_d, ovf_d, idx_d);
            sel_q     <= N_DIGITS'(1) << idx_d;
            case (state_q)
                S_IDLE: begin
                    if (load_fire) begin
                        state_q    <= S_CONV;
                        shift_q    <= ld_if.value;
                        bcd_q      <= '0;
                        bit_cnt_q  <= CW'(IN_W - 1);
                        ovf_pend_q <= (64'(ld_if.value) > MAX_VAL);
                    end
                end
                S_CONV: begin
                    shift_q   <= shift_q << 1;
                    bcd_q     <= bcd_step;
                    bit_cnt_q <= bit_cnt_q - 1'b1;
                    if (bit_cnt_q == '0) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign seg       = seg_q;
    assign digit_sel = sel_q;
    assign overflow  = ovf_q;
endmodule

// File: tb/tb_sevenseg_scan.sv
// Scoreboard bench for sevenseg_scan: stimulus queues expected scan frames and
// ready-low durations; a monitor pops and compares them as the DUT produces them.
module tb_sevenseg_scan;
    localparam int N  = 4;
    localparam int W  = 14;
    localparam int RD = 4;

    localparam logic [6:0] S0 = 7'b0000001;
    localparam logic [6:0] S1 = 7'b1001111;
    localparam logic [6:0] S2 = 7'b0010010;
    localparam logic [6:0] S3 = 7'b0000110;
    localparam logic [6:0] S4 = 7'b1001100;
    localparam logic [6:0] S5 = 7'b0100100;
    localparam logic [6:0] S7 = 7'b0001111;
    localparam logic [6:0] S9 = 7'b0000100;
    localparam logic [6:0] SD = 7'b1111110;
`ifdef SEVENSEG_BLANK_EN
    localparam logic [6:0] LZ = 7'b1111111;
`else
    localparam logic [6:0] LZ = 7'b0000001;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sevenseg_scan_if #(.IN_W(W)) ld_if ();
    logic [6:0]   seg;
    logic [N-1:0] digit_sel;
    logic         overflow;

    sevenseg_scan #(.N_DIGITS(N), .IN_W(W), .REFRESH_DIV(RD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ld_if     (ld_if.slave),
        .seg       (seg),
        .digit_sel (digit_sel),
        .overflow  (overflow)
    );

    typedef struct {
        logic [N-1:0] sel;
        logic [6:0]   seg;
        logic         ovf;
    } frm_t;

    frm_t frm_q[$];
    int   low_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // Monitor: a digit_sel change is one scan output; a ready rise ends a conversion.
    initial begin
        logic [N-1:0] prev;
        int gap;
        int low;
        prev = N'(1);
        gap  = 0;
        low  = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                gap  = 0;
                low  = 0;
                prev = digit_sel;
            end else begin
                gap++;
                if (digit_sel !== prev) begin
                    if (frm_q.size() > 0) begin
                        frm_t e;
                        e = frm_q.pop_front();
                        check("scan_sel", 32'(digit_sel), 32'(e.sel));
                        check("scan_seg", 32'(seg), 32'(e.seg));
                        check("scan_ovf", 32'(overflow), 32'(e.ovf));
                        check("scan_period", 32'(gap), 32'(RD));
                    end
                    gap  = 0;
                    prev = digit_sel;
                end
                if (!ld_if.load_ready) low++;
                else begin
                    if (low > 0 && low_q.size() > 0) begin
                        int e;
                        e = low_q.pop_front();
                        check("ready_low_cycles", 32'(low), 32'(e));
                    end
                    low = 0;
                end
            end
        end
    end

    task automatic wait_ready();
        int k;
        k = 0;
        while (ld_if.load_ready !== 1'b1 && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 100) timeout("wait_ready");
    endtask

    task automatic load(input logic [W-1:0] v, input int hold);
        wait_ready();
        ld_if.load_valid = 1'b1;
        ld_if.value      = v;
        @(posedge clk); #1;
        low_q.push_back(W);
        if (hold > 0) begin
            ld_if.value = W'(5555);
            repeat (hold) @(posedge clk);
            #1;
        end
        ld_if.load_valid = 1'b0;
    endtask

    task automatic show(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                        input logic [6:0] s3, input logic ov);
        int k;
        frm_t f;
        wait_ready();
        k = 0;
        while (digit_sel !== N'(8) && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 100) timeout("wait_last_digit");
        @(negedge clk); #1;
        f.ovf = ov;
        f.sel = N'(1); f.seg = s0; frm_q.push_back(f);
        f.sel = N'(2); f.seg = s1; frm_q.push_back(f);
        f.sel = N'(4); f.seg = s2; frm_q.push_back(f);
        f.sel = N'(8); f.seg = s3; frm_q.push_back(f);
        k = 0;
        while (frm_q.size() > 0 && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 200) begin
            timeout("frame_drain");
            frm_q.delete();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_seg"}, 32'(seg), 32'(7'b1111111));
        check({tag, "_sel"}, 32'(digit_sel), 32'(N'(1)));
        check({tag, "_ready"}, 32'(ld_if.load_ready), 32'(1'b1));
        check({tag, "_ovf"}, 32'(overflow), 32'(1'b0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        ld_if.load_valid = 1'b0;
        ld_if.value      = '0;
        rst_n            = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");

        rst_n = 1'b1;
        k = 0;
        do begin
            @(posedge clk); #1;
            k++;
        end while (digit_sel === N'(1) && k < 20);
        check("first_advance_cycles", 32'(k), 32'(RD));

        show(LZ, LZ, LZ, S0, 1'b0);
        load(W'(1234), 0);   show(S1, S2, S3, S4, 1'b0);
        load(W'(4321), 14);  show(S4, S3, S2, S1, 1'b0);
        load(W'(10000), 0);  show(SD, SD, SD, SD, 1'b1);
        load(W'(9999), 0);   show(S9, S9, S9, S9, 1'b0);
        load(W'(7), 0);      show(LZ, LZ, LZ, S7, 1'b0);
        load(W'(0), 0);      show(LZ, LZ, LZ, S0, 1'b0);
        load(W'(16383), 0);  show(SD, SD, SD, SD, 1'b1);
        load(W'(105), 0);    show(LZ, S1, S0, S5, 1'b0);

        // Abort a conversion of 9999 with reset a few cycles in.
        wait_ready();
        ld_if.load_valid = 1'b1;
        ld_if.value      = W'(9999);
        @(posedge clk); #1;
        ld_if.load_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("abort_ready_after", 32'(ld_if.load_ready), 32'(1'b1));
        show(LZ, LZ, LZ, S0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
